// File: rtl/logic_unit_stream.sv
// logic_unit_stream: registered bitwise logic unit with valid/ready handshake
// on both sides and a packet-accumulate mode (Op=111) that folds a stream of
// In1^In2 beats into a running XOR checksum with a saturating beat count.
//
// Ports:
//   Clk, Reset            rising-edge clock, synchronous active-high reset
//   In1, In2              WIDTH-bit operands
//   Op                    operation select (000 AND .. 110 NOT In1, 111 ACC)
//   In_First, In_Last     packet delimiters, used only when Op=111
//   In_Valid / In_Ready   input handshake (In_Ready is combinational)
//   Out                   registered result
//   Out_Count             beats folded into the result (1 for single ops)
//   Out_Parity, Out_Zero  XOR-reduction of Out, Out == 0
//   Out_Valid / Out_Ready output handshake
module logic_unit_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [2:0]       Op,
  input  logic             In_First,
  input  logic             In_Last,
  input  logic             In_Valid,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out,
  output logic [CNT_W-1:0] Out_Count,
  output logic             Out_Parity,
  output logic             Out_Zero,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;
  localparam logic [2:0] OP_ACC  = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [WIDTH-1:0] out_q,     out_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             par_q,     par_d;
  logic             zero_q,    zero_d;
  logic             valid_q,   valid_d;

  logic             accept;
  logic [WIDTH-1:0] beat_x;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_next;

  // Room for a new beat when the output slot is empty or draining this cycle.
  assign In_Ready = ~valid_q | Out_Ready;
  assign accept   = In_Valid & In_Ready;
  assign beat_x   = In1 ^ In2;

  // Bitwise result for the single ops; ACC uses beat_x instead.
  always_comb begin
    single_res = '0;
    case (Op)
      OP_AND:  single_res = In1 & In2;
      OP_OR:   single_res = In1 | In2;
      OP_XOR:  single_res = In1 ^ In2;
      OP_XNOR: single_res = ~(In1 ^ In2);
      OP_NAND: single_res = ~(In1 & In2);
      OP_NOR:  single_res = ~(In1 | In2);
      OP_NOT:  single_res = ~In1;
      default: single_res = '0;
    endcase
  end

  // Continuation of an open packet; the counter sticks at all-ones.
  assign acc_next = acc_q ^ beat_x;
  assign cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_cnt_d = out_cnt_q;
    par_d     = par_q;
    zero_d    = zero_q;
    valid_d   = valid_q;

    if (valid_q && Out_Ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (Op != OP_ACC) begin
        // Single ops leave packet state untouched so they may interleave.
        out_d     = single_res;
        out_cnt_d = CNT_W'(1);
        par_d     = ^single_res;
        zero_d    = (single_res == '0);
        valid_d   = 1'b1;
      end else if (state_q == ST_IDLE || In_First) begin
        // Start of a packet; In_First while open restarts and drops the partial.
        acc_d = beat_x;
        cnt_d = CNT_W'(1);
        if (In_Last) begin
          state_d   = ST_IDLE;
          out_d     = beat_x;
          out_cnt_d = CNT_W'(1);
          par_d     = ^beat_x;
          zero_d    = (beat_x == '0);
          valid_d   = 1'b1;
        end else begin
          state_d = ST_ACC;
        end
      end else begin
        acc_d = acc_next;
        cnt_d = cnt_next;
        if (In_Last) begin
          state_d   = ST_IDLE;
          out_d     = acc_next;
          out_cnt_d = cnt_next;
          par_d     = ^acc_next;
          zero_d    = (acc_next == '0);
          valid_d   = 1'b1;
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_q     <= '0;
      out_cnt_q <= '0;
      par_q     <= 1'b0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_cnt_q <= out_cnt_d;
      par_q     <= par_d;
      zero_q    <= zero_d;
      valid_q   <= valid_d;
    end
  end

  assign Out        = out_q;
  assign Out_Count  = out_cnt_q;
  assign Out_Parity = par_q;
  assign Out_Zero   = zero_q;
  assign Out_Valid  = valid_q;

endmodule

// File: doc/logic_unit_stream.md
Name: logic_unit_stream

Overview:
- Parametrised, registered successor to the team's 8-bit combinational XOR gate in the DSP datapath.
- Performs one of eight bitwise operations on two WIDTH-bit operands. Includes a packet-accumulate mode that folds a stream into a running XOR checksum with a beat count.
- Sits between the operand fetch stage and the result bus. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 8, width of the beat counter reported in accumulate mode (>=1).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- In1  input  WIDTH  operand A.
- In2  input  WIDTH  operand B.
- Op  input  3  operation select, sampled with the input beat.
- In_First  input  1  first beat of an accumulate packet (Op=111 only).
- In_Last  input  1  last beat of an accumulate packet (Op=111 only).
- In_Valid  input  1  input beat valid.
- In_Ready  output  1  block can accept a beat this cycle.
- Out  output  WIDTH  result.
- Out_Count  output  CNT_W  beats folded into an accumulate result; 1 for single ops.
- Out_Parity  output  1  XOR-reduction of Out.
- Out_Zero  output  1  Out == 0.
- Out_Valid  output  1  result valid.
- Out_Ready  input  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock (Clk). Reset is synchronous and active-high.
- Reset values: Out=0, Out_Count=0, Out_Parity=0, Out_Zero=1, Out_Valid=0, accumulator=0, beat counter=0, state=IDLE. Reset overrides every other input in the same cycle. Reset mid-packet discards the partial accumulation and any held, unaccepted result.
- Handshake:
  - In_Ready = ~Out_Valid | Out_Ready (combinational).
  - An input beat is accepted when In_Valid & In_Ready.
  - An output beat is transferred when Out_Valid & Out_Ready.
  - Out and its flags hold stable while Out_Valid=1 and Out_Ready=0.
- Op encoding (bitwise, WIDTH bits):
  - 000 AND; 001 OR; 010 XOR; 011 XNOR; 100 NAND; 101 NOR.
  - 110 NOT In1 (In2 ignored).
  - 111 ACC: fold (In1 ^ In2) into the accumulator.
- Single ops (000-110):
  - Latency 1. The result is registered on the accept edge and Out_Valid=1 the next cycle; Out_Count=1.
  - In_First and In_Last are ignored.
  - Full throughput: one beat per cycle while Out_Ready=1.
- Accumulate FSM, states IDLE and ACC:
  - IDLE, ACC beat accepted:
    - acc <= In1^In2; cnt <= 1.
    - If In_Last, emit the result (Out=In1^In2, Out_Count=1) and stay in IDLE. Otherwise go to ACC.
    - In_First is optional in IDLE.
  - ACC, ACC beat without In_First: acc <= acc^In1^In2; cnt <= cnt+1, saturating at 2^CNT_W-1.
    - If In_Last, emit Out=new acc and Out_Count=new cnt, then return to IDLE.
  - ACC, ACC beat with In_First: restart. The partial result is discarded and the beat is handled as in IDLE.
  - ACC, single-op beat: processed normally and emitted. Accumulator, counter and state are unchanged, so interleaving is allowed.
  - Non-last ACC beats produce no output but still require In_Ready=1 to be accepted.
- Flags: Out_Parity and Out_Zero are registered together with Out, from the same value.
- Width: all operations are bitwise with no carry. The counter saturates and never wraps.

Test Plan:
- Reset, then Op=010 with In1=8'hA5, In2=8'h0F -> next cycle Out=8'hAA, Out_Valid=1, Out_Count=1, Out_Parity=0, Out_Zero=0.
- Sweep Op 000..110 with In1=8'hC3, In2=8'h5A and Out_Ready=1 -> Out sequence 42, DB, 99, 66, BD, 24, 3C (hex), one per cycle, no bubbles.
- Backpressure: Out_Ready=0 after the first result -> In_Ready=0, Out stays 8'hAA until Out_Ready=1. The second beat is not lost.
- Accumulate: 3 beats Op=111 (First on beat 1, Last on beat 3), operand pairs (01,00), (02,00), (04,08) -> single output Out=8'h0F, Out_Count=3, Out_Parity=0. No outputs appear for beats 1-2.
- Interleave and restart:
  - ACC beat (10,00), then single AND (FF,0F) -> Out=0F, accumulator kept.
  - Then ACC beat with In_First (33,00) and In_Last -> Out=8'h33, Out_Count=1, partial 10 discarded.
- Reset mid-packet after 2 ACC beats, then ACC beat (07,00) with Last -> Out=8'h07, Out_Count=1. Separately, CNT_W=2 with 5 beats -> Out_Count=3 (saturated).
